apb_master_arbiter: RTL

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

---
 rtl/apb_master_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration in IDLE, then a standard SETUP/ACCESS transfer.
// Optional ACCESS timeout is enabled with macro APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        REQ0,
  input  logic [31:0] ADDR0,
  input  logic        WRITE0,
  input  logic [31:0] WDATA0,
  output logic        DONE0,
  output logic [31:0] RDATA0,
  output logic        ERR0,
  input  logic        REQ1,
  input  logic [31:0] ADDR1,
  input  logic        WRITE1,
  input  logic [31:0] WDATA1,
  output logic        DONE1,
  output logic [31:0] RDATA1,
  output logic        ERR1,
  output logic [31:0] PADDR,
  output logic [15:0] PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int unsigned CNT_W = 16;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;
  logic        r_owner;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_gnt_valid;
  logic        w_gnt_sel;
  logic [31:0] w_gnt_addr;
  logic        w_timeout;
  logic        w_end;

  logic [31:0] w_paddr_nxt;
  logic [15:0] w_psel_nxt;
  logic        w_penable_nxt;
  logic        w_pwrite_nxt;
  logic [31:0] w_pwdata_nxt;
  logic        w_done0_nxt;
  logic        w_done1_nxt;
  logic [31:0] w_rdata0_nxt;
  logic [31:0] w_rdata1_nxt;
  logic        w_err0_nxt;
  logic        w_err1_nxt;
  logic        w_last_nxt;
  logic        w_owner_nxt;
  logic [31:0] w_rdata_fin;
  logic        w_err_fin;

  // A requester is ineligible during the cycle its DONE is high.
  assign w_elig0     = REQ0 & ~DONE0;
  assign w_elig1     = REQ1 & ~DONE1;
  assign w_gnt_valid = w_elig0 | w_elig1;
  assign w_gnt_sel   = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
  assign w_gnt_addr  = w_gnt_sel ? ADDR1 : ADDR0;

`ifdef APB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_tcnt;
  logic [CNT_W-1:0] w_tcnt_nxt;

  assign w_timeout  = (r_state == S_ACCESS) && !PREADY &&
                      (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_tcnt_nxt = ((r_state == S_ACCESS) && !w_end) ? r_tcnt + CNT_W'(1) : '0;
`else
  assign w_timeout  = 1'b0;
`endif

  assign w_end = (r_state == S_ACCESS) && (PREADY || w_timeout);

  // Completion payload: read data only for successful reads; timeout reports an error.
  assign w_rdata_fin = (PREADY && !PWRITE) ? PRDATA : 32'd0;
  assign w_err_fin   = PREADY ? PSLVERR : 1'b1;

  // State and output registers
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      PADDR   <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      DONE0   <= 1'b0;
      DONE1   <= 1'b0;
      RDATA0  <= '0;
      RDATA1  <= '0;
      ERR0    <= 1'b0;
      ERR1    <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      r_tcnt  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_owner <= w_owner_nxt;
      PADDR   <= w_paddr_nxt;
      PSEL    <= w_psel_nxt;
      PENABLE <= w_penable_nxt;
      PWRITE  <= w_pwrite_nxt;
      PWDATA  <= w_pwdata_nxt;
      DONE0   <= w_done0_nxt;
      DONE1   <= w_done1_nxt;
      RDATA0  <= w_rdata0_nxt;
      RDATA1  <= w_rdata1_nxt;
      ERR0    <= w_err0_nxt;
      ERR1    <= w_err1_nxt;
`ifdef APB_ARB_TIMEOUT_EN
      r_tcnt  <= w_tcnt_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_gnt_valid) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_end) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_paddr_nxt   = PADDR;
    w_psel_nxt    = PSEL;
    w_penable_nxt = PENABLE;
    w_pwrite_nxt  = PWRITE;
    w_pwdata_nxt  = PWDATA;
    w_done0_nxt   = 1'b0;
    w_done1_nxt   = 1'b0;
    w_rdata0_nxt  = RDATA0;
    w_rdata1_nxt  = RDATA1;
    w_err0_nxt    = ERR0;
    w_err1_nxt    = ERR1;
    w_last_nxt    = r_last;
    w_owner_nxt   = r_owner;
    case (r_state)
      S_IDLE: begin
        w_psel_nxt    = '0;
        w_penable_nxt = 1'b0;
        if (w_gnt_valid) begin
          w_paddr_nxt  = w_gnt_addr;
          w_pwrite_nxt = w_gnt_sel ? WRITE1 : WRITE0;
          w_pwdata_nxt = w_gnt_sel ? WDATA1 : WDATA0;
          w_psel_nxt   = 16'(1) << w_gnt_addr[27:24];
          w_last_nxt   = w_gnt_sel;
          w_owner_nxt  = w_gnt_sel;
        end
      end
      S_SETUP: w_penable_nxt = 1'b1;
      S_ACCESS: begin
        if (w_end) begin
          w_psel_nxt    = '0;
          w_penable_nxt = 1'b0;
          if (r_owner) begin
            w_done1_nxt  = 1'b1;
            w_rdata1_nxt = w_rdata_fin;
            w_err1_nxt   = w_err_fin;
          end else begin
            w_done0_nxt  = 1'b1;
            w_rdata0_nxt = w_rdata_fin;
            w_err0_nxt   = w_err_fin;
          end
        end
      end
      default: begin
        w_psel_nxt    = '0;
        w_penable_nxt = 1'b0;
      end
    endcase
  end

endmodule
